index_mask_builder: RTL and testbench

Streaming index-to-mask decoder: the inverse of the shared leading/trailing-zero counter. It accepts a sequence of bit indices over a valid/ready channel and sets the corresponding bits in an accumulating `WIDTH`-bit vector. On the beat flagged `last`, it emits the assembled mask, a popcount and error flags over a second valid/ready channel. It sits in `gpgpu_top/shared` and rebuilds lane/active masks from index streams produced by schedulers and reconvergence logic.

---
 rtl/index_mask_builder_pkg.sv | 18 +
 rtl/index_mask_builder_if.sv | 33 +++
 rtl/index_mask_builder_index_decoder.sv | 27 ++
 rtl/index_mask_builder.sv | 113 +++++++++++
 tb/tb_index_mask_builder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/index_mask_builder_pkg.sv
// Shared sizing helpers and state encoding for the index-to-mask builder.
// Index and count widths match the ones the zero counter uses.
package index_mask_builder_pkg;

    typedef enum logic {
        IMB_IDLE,
        IMB_BUILD
    } imb_state_e;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/index_mask_builder_if.sv
// Index-beat input channel and mask-result output channel, both valid/ready.
// The master drives index beats and consumes results; the slave is the builder.
interface index_mask_builder_if #(
    parameter int WIDTH = 32
);
    import index_mask_builder_pkg::*;

    localparam int IDX_W = idx_width(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             idx_valid_i;
    logic             idx_ready_o;
    logic [IDX_W-1:0] idx_i;
    logic             idx_empty_i;
    logic             idx_last_i;
    logic             mask_valid_o;
    logic             mask_ready_i;
    logic [WIDTH-1:0] mask_o;
    logic [CNT_W-1:0] mask_cnt_o;
    logic             mask_dup_o;
    logic             mask_oob_o;

    modport master (
        output idx_valid_i, idx_i, idx_empty_i, idx_last_i, mask_ready_i,
        input  idx_ready_o, mask_valid_o, mask_o, mask_cnt_o, mask_dup_o, mask_oob_o
    );

    modport slave (
        input  idx_valid_i, idx_i, idx_empty_i, idx_last_i, mask_ready_i,
        output idx_ready_o, mask_valid_o, mask_o, mask_cnt_o, mask_dup_o, mask_oob_o
    );

endinterface

// File: rtl/index_mask_builder_index_decoder.sv
// Combinational index-to-one-hot decoder with optional MSB-first numbering.
// Out-of-range indices raise oob and produce an all-zero vector.
module index_decoder
    import index_mask_builder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit MODE  = 1'b0,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] onehot,
    output logic             oob
);

    int pos;

    always_comb begin
        pos    = MODE ? (WIDTH - 1 - int'(idx)) : int'(idx);
        oob    = en && (int'(idx) >= WIDTH);
        onehot = '0;
        for (int b = 0; b < WIDTH; b++) begin
            onehot[b] = en && !oob && (b == pos);
        end
    end

endmodule

// File: rtl/index_mask_builder.sv
// Accumulates a stream of bit indices into a mask and emits it, with a
// distinct-bit count and sticky dup/oob flags, on the beat flagged last.
module index_mask_builder
    import index_mask_builder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit MODE  = 1'b0
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    index_mask_builder_if.slave bus
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);

    imb_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dup_q, dup_d, oob_q, oob_d;
    logic             hit_oob, hit_dup, accept, emit;

    logic [WIDTH-1:0] mask_q;
    logic [CNT_W-1:0] mask_cnt_q;
    logic             mask_dup_q, mask_oob_q, mask_valid_q;

    index_decoder #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .IDX_W (IDX_W)
    ) u_index_decoder (
        .idx    (bus.idx_i),
        .en     (~bus.idx_empty_i),
        .onehot (hit),
        .oob    (hit_oob)
    );

    // Ready looks only at the output register, so a full, stalled output freezes intake.
    assign bus.idx_ready_o = ~mask_valid_q | bus.mask_ready_i;
    assign accept          = bus.idx_valid_i & bus.idx_ready_o;
    assign emit            = accept & bus.idx_last_i;
    assign hit_dup         = |(acc_q & hit);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dup_d   = dup_q;
        oob_d   = oob_q;
        if (accept) begin
            acc_d   = acc_q | hit;
            dup_d   = dup_q | hit_dup;
            oob_d   = oob_q | hit_oob;
            state_d = bus.idx_last_i ? IMB_IDLE : IMB_BUILD;
            if ((|hit) && !hit_dup) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IMB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The last beat hands the updated accumulator to the output register and clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
            dup_q <= 1'b0;
            oob_q <= 1'b0;
        end else if (emit) begin
            acc_q <= '0;
            cnt_q <= '0;
            dup_q <= 1'b0;
            oob_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            dup_q <= dup_d;
            oob_q <= oob_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_valid_q <= 1'b0;
            mask_q       <= '0;
            mask_cnt_q   <= '0;
            mask_dup_q   <= 1'b0;
            mask_oob_q   <= 1'b0;
        end else if (emit) begin
            mask_valid_q <= 1'b1;
            mask_q       <= acc_d;
            mask_cnt_q   <= cnt_d;
            mask_dup_q   <= dup_d;
            mask_oob_q   <= oob_d;
        end else if (bus.mask_ready_i) begin
            mask_valid_q <= 1'b0;
        end
    end

    assign bus.mask_valid_o = mask_valid_q;
    assign bus.mask_o       = mask_q;
    assign bus.mask_cnt_o   = mask_cnt_q;
    assign bus.mask_dup_o   = mask_dup_q;
    assign bus.mask_oob_o   = mask_oob_q;

endmodule

// File: tb/tb_index_mask_builder.sv
// Drives one index stream into three builders (8/LSB, 8/MSB, 6/LSB) and
// checks every consumed result against hand-computed expectations.
module tb_index_mask_builder;
    import index_mask_builder_pkg::*;

    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] cnt;
        logic       dup;
        logic       oob;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       empty = 1'b0;
    logic       last = 1'b0;
    logic       mready = 1'b1;
    logic [2:0] idx = 3'd0;

    always #5 clk = ~clk;

    index_mask_builder_if #(.WIDTH(8)) if_a ();
    index_mask_builder_if #(.WIDTH(8)) if_b ();
    index_mask_builder_if #(.WIDTH(6)) if_c ();

    assign if_a.idx_valid_i = valid;
    assign if_a.idx_i = idx;
    assign if_a.idx_empty_i = empty;
    assign if_a.idx_last_i = last;
    assign if_a.mask_ready_i = mready;
    assign if_b.idx_valid_i = valid;
    assign if_b.idx_i = idx;
    assign if_b.idx_empty_i = empty;
    assign if_b.idx_last_i = last;
    assign if_b.mask_ready_i = mready;
    assign if_c.idx_valid_i = valid;
    assign if_c.idx_i = idx;
    assign if_c.idx_empty_i = empty;
    assign if_c.idx_last_i = last;
    assign if_c.mask_ready_i = mready;

    index_mask_builder #(.WIDTH(8), .MODE(1'b0)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(if_a.slave));
    index_mask_builder #(.WIDTH(8), .MODE(1'b1)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(if_b.slave));
    index_mask_builder #(.WIDTH(6), .MODE(1'b0)) dut_c (.clk_i(clk), .rst_ni(rst_n), .bus(if_c.slave));

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t ea, eb, ec;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [7:0] m,
                       input logic [3:0] c, input logic d, input logic o);
        chk({tag, "_mask"}, 32'(m), 32'(e.mask));
        chk({tag, "_cnt"},  32'(c), 32'(e.cnt));
        chk({tag, "_dup"},  32'(d), 32'(e.dup));
        chk({tag, "_oob"},  32'(o), 32'(e.oob));
    endtask

    function automatic exp_t mk(input logic [7:0] m, input logic [3:0] c, input logic d, input logic o);
        exp_t e;
        e.mask = m;
        e.cnt  = c;
        e.dup  = d;
        e.oob  = o;
        return e;
    endfunction

    task automatic push(input exp_t a, input exp_t b, input exp_t c);
        q_a.push_back(a);
        q_b.push_back(b);
        q_c.push_back(c);
    endtask

    // Monitors: one per builder, each pops on an output handshake.
    always @(negedge clk) begin
        if (rst_n && if_a.mask_valid_o && if_a.mask_ready_i) begin
            if (q_a.size() == 0) chk("a_extra_result", 32'(q_a.size()), 32'd1);
            else begin
                ea = q_a.pop_front();
                cmp("a", ea, 8'(if_a.mask_o), 4'(if_a.mask_cnt_o), if_a.mask_dup_o, if_a.mask_oob_o);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_b.mask_valid_o && if_b.mask_ready_i) begin
            if (q_b.size() == 0) chk("b_extra_result", 32'(q_b.size()), 32'd1);
            else begin
                eb = q_b.pop_front();
                cmp("b", eb, 8'(if_b.mask_o), 4'(if_b.mask_cnt_o), if_b.mask_dup_o, if_b.mask_oob_o);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_c.mask_valid_o && if_c.mask_ready_i) begin
            if (q_c.size() == 0) chk("c_extra_result", 32'(q_c.size()), 32'd1);
            else begin
                ec = q_c.pop_front();
                cmp("c", ec, 8'(if_c.mask_o), 4'(if_c.mask_cnt_o), if_c.mask_dup_o, if_c.mask_oob_o);
            end
        end
    end

    task automatic check_rst_outs(input string tag);
        chk({tag, "_a_outs"}, 32'({if_a.mask_valid_o, if_a.mask_o, if_a.mask_cnt_o, if_a.mask_dup_o, if_a.mask_oob_o}), 32'd0);
        chk({tag, "_b_outs"}, 32'({if_b.mask_valid_o, if_b.mask_o, if_b.mask_cnt_o, if_b.mask_dup_o, if_b.mask_oob_o}), 32'd0);
        chk({tag, "_c_outs"}, 32'({if_c.mask_valid_o, if_c.mask_o, if_c.mask_cnt_o, if_c.mask_dup_o, if_c.mask_oob_o}), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [2:0] i, input logic e, input logic l);
        int   cyc;
        logic acc;
        valid = 1'b1;
        idx   = i;
        empty = e;
        last  = l;
        cyc   = 0;
        acc   = 1'b0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = if_a.idx_ready_o;
            @(posedge clk);
            cyc++;
        end
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        #1;
        valid = 1'b0;
        empty = 1'b0;
        last  = 1'b0;
    endtask

    initial begin
        int w;
        repeat (2) @(posedge clk);
        #1;
        check_rst_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(if_a.idx_ready_o), 32'd1);

        // 3, 0, 7(last)
        send(3'd3, 1'b0, 1'b0);
        send(3'd0, 1'b0, 1'b0);
        push(mk(8'h89, 4'd3, 1'b0, 1'b0), mk(8'h91, 4'd3, 1'b0, 1'b0), mk(8'h09, 4'd2, 1'b0, 1'b1));
        send(3'd7, 1'b0, 1'b1);
        chk("latency_valid", 32'(if_a.mask_valid_o), 32'd1);

        // 2, 2(last): duplicate
        send(3'd2, 1'b0, 1'b0);
        push(mk(8'h04, 4'd1, 1'b1, 1'b0), mk(8'h20, 4'd1, 1'b1, 1'b0), mk(8'h04, 4'd1, 1'b1, 1'b0));
        send(3'd2, 1'b0, 1'b1);

        // empty + last: flags cleared from the previous mask
        push(mk(8'h00, 4'd0, 1'b0, 1'b0), mk(8'h00, 4'd0, 1'b0, 1'b0), mk(8'h00, 4'd0, 1'b0, 1'b0));
        send(3'd0, 1'b1, 1'b1);

        // 6, 1(last): out of range for the 6-bit builder
        send(3'd6, 1'b0, 1'b0);
        push(mk(8'h42, 4'd2, 1'b0, 1'b0), mk(8'h42, 4'd2, 1'b0, 1'b0), mk(8'h02, 4'd1, 1'b0, 1'b1));
        send(3'd1, 1'b0, 1'b1);

        // Backpressure: result held, next last beat stalled, then replaced without a bubble
        repeat (2) @(posedge clk);
        #1;
        mready = 1'b0;
        push(mk(8'h20, 4'd1, 1'b0, 1'b0), mk(8'h04, 4'd1, 1'b0, 1'b0), mk(8'h20, 4'd1, 1'b0, 1'b0));
        send(3'd5, 1'b0, 1'b1);
        valid = 1'b1;
        idx   = 3'd1;
        last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_idx_ready", 32'(if_a.idx_ready_o), 32'd0);
            chk("bp_mask_hold", 32'(if_a.mask_o), 32'h20);
            chk("bp_valid_hold", 32'(if_a.mask_valid_o), 32'd1);
            @(posedge clk);
        end
        #1;
        mready = 1'b1;
        push(mk(8'h02, 4'd1, 1'b0, 1'b0), mk(8'h40, 4'd1, 1'b0, 1'b0), mk(8'h02, 4'd1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        valid = 1'b0;
        last  = 1'b0;
        chk("no_bubble_valid", 32'(if_a.mask_valid_o), 32'd1);
        chk("replace_mask", 32'(if_a.mask_o), 32'h02);

        // Reset mid-build discards the partial mask
        repeat (2) @(posedge clk);
        #1;
        send(3'd4, 1'b0, 1'b0);
        send(3'd5, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_rst_outs("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(if_a.idx_ready_o), 32'd1);
        push(mk(8'h02, 4'd1, 1'b0, 1'b0), mk(8'h40, 4'd1, 1'b0, 1'b0), mk(8'h02, 4'd1, 1'b0, 1'b0));
        send(3'd1, 1'b0, 1'b1);

        w = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("drain_pending", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
